// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA fixed-priority memory arbiter with starvation bound
// Optional macro: MEM_ARB_TIMEOUT_EN enables the BUSY watchdog and err pulse.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_WAIT       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk50M,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_is_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_is_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_req,
    output logic              mem_is_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_owner,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic [3:0]          starve_q, starve_d;
    logic                grant_m0, grant_m1;
    logic                timeout;
    logic [DATA_W-1:0]   resp_data;

    // Master 1 wins only when the CPU is idle or has used up its MAX_WAIT grants.
    assign grant_m1 = m1_req && (!m0_req || (starve_q == 4'(MAX_WAIT)));
    assign grant_m0 = m0_req && !grant_m1;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    assign timeout = (state_q == BUSY) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_comb begin
        tmo_d = (state_q == BUSY) ? tmo_q + 16'd1 : 16'd0;
        err_d = (state_q == BUSY) && timeout && !mem_ack;
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            tmo_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout    = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            starve_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_m0 || grant_m1) state_d = BUSY;
            BUSY:    if (mem_ack || timeout) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A real mem_ack beats a coincident watchdog expiry.
    assign resp_data = mem_ack ? mem_rdata : {DATA_W{1'b1}};

    always_comb begin
        owner_d    = owner_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        starve_d   = starve_q;
        if (state_q == IDLE) begin
            if (grant_m1) begin
                owner_d    = 1'b1;
                is_write_d = m1_is_write;
                addr_d     = m1_addr;
                wdata_d    = m1_wdata;
                starve_d   = 4'd0;
            end else if (grant_m0) begin
                owner_d    = 1'b0;
                is_write_d = m0_is_write;
                addr_d     = m0_addr;
                wdata_d    = m0_wdata;
                if (m1_req && (starve_q != 4'(MAX_WAIT)))
                    starve_d = starve_q + 4'd1;
            end
        end else if ((state_q == BUSY) && (mem_ack || timeout)) begin
            if (owner_q) m1_rdata_d = resp_data;
            else         m0_rdata_d = resp_data;
        end
    end

    always_comb begin
        mem_req = (state_q == BUSY);
        m0_ack  = (state_q == ACK) && !owner_q;
        m1_ack  = (state_q == ACK) && owner_q;
    end

    assign grant_owner  = owner_q;
    assign mem_is_write = is_write_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk50M = 1'b0;
    logic        rst;
    logic        m0_req, m0_is_write, m1_req, m1_is_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_is_write, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant_owner, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk50M = ~clk50M;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk50M(clk50M), .rst(rst),
        .m0_req(m0_req), .m0_is_write(m0_is_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_is_write(m1_is_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_is_write(mem_is_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant_owner(grant_owner), .err(err)
    );

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seq [10];
        seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        m0_req = 1'b0; m0_is_write = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_is_write = 1'b0; m1_addr = '0; m1_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_m0_ack", 32'(m0_ack), 32'd0);
        check("rst_m1_ack", 32'(m1_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_owner", 32'(grant_owner), 32'd0);
        check("rst_is_write", 32'(mem_is_write), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);

        // Single read by master 0
        m0_req = 1'b1; m0_addr = 32'h0000_0010;
        tick();
        check("rd_mem_req", 32'(mem_req), 32'd1);
        check("rd_owner", 32'(grant_owner), 32'd0);
        check("rd_addr", mem_addr, 32'h0000_0010);
        check("rd_is_write", 32'(mem_is_write), 32'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; m0_req = 1'b0;
        check("rd_m0_ack", 32'(m0_ack), 32'd1);
        check("rd_m1_ack", 32'(m1_ack), 32'd0);
        check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd_ack_mem_req", 32'(mem_req), 32'd0);
        check("rd_err", 32'(err), 32'd0);
        tick();
        check("rd_ack_single", 32'(m0_ack), 32'd0);
        check("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // Single write by master 1
        m1_req = 1'b1; m1_is_write = 1'b1; m1_addr = 32'h0040_0000; m1_wdata = 32'h1234_5678;
        tick();
        check("wr_owner", 32'(grant_owner), 32'd1);
        check("wr_is_write", 32'(mem_is_write), 32'd1);
        check("wr_addr", mem_addr, 32'h0040_0000);
        check("wr_wdata", mem_wdata, 32'h1234_5678);
        m1_addr = 32'h0; m1_wdata = 32'h0;
        tick();
        check("wr_addr_stable", mem_addr, 32'h0040_0000);
        check("wr_wdata_stable", mem_wdata, 32'h1234_5678);
        check("wr_mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        mem_ack = 1'b0; m1_req = 1'b0; m1_is_write = 1'b0;
        check("wr_m1_ack", 32'(m1_ack), 32'd1);
        check("wr_m0_ack", 32'(m0_ack), 32'd0);
        check("wr_m1_rdata", m1_rdata, 32'hAAAA_5555);
        check("wr_m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
        tick();
        check("wr_idle_ack", 32'(m1_ack), 32'd0);
        check("wr_idle_req", 32'(mem_req), 32'd0);
        tick();
        check("wr_stay_idle", 32'(mem_req), 32'd0);

        // Contention: both held, CPU wins until the starvation bound forces master 1
        m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("cont_owner_%0d", i), 32'(grant_owner), 32'(seq[i]));
            check($sformatf("cont_addr_%0d", i), mem_addr, seq[i] ? 32'h200 : 32'h100);
            mem_ack = 1'b1; mem_rdata = 32'(i + 100);
            tick();
            mem_ack = 1'b0;
            check($sformatf("cont_ack_%0d", i), {30'd0, m1_ack, m0_ack}, seq[i] ? 32'd2 : 32'd1);
            check($sformatf("cont_rdata_%0d", i), seq[i] ? m1_rdata : m0_rdata, 32'(i + 100));
            tick();
            check($sformatf("cont_idle_%0d", i), 32'(mem_req), 32'd0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Back-to-back on master 0 with req held through ACK
        m0_req = 1'b1; m0_addr = 32'h300;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check("b2b_ack", 32'(m0_ack), 32'd1);
        check("b2b_ack_req", 32'(mem_req), 32'd0);
        tick();
        check("b2b_no_double", 32'(mem_req), 32'd0);
        check("b2b_no_ack", 32'(m0_ack), 32'd0);
        tick();
        check("b2b_regrant", 32'(mem_req), 32'd1);
        check("b2b_owner", 32'(grant_owner), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0; m0_req = 1'b0;
        check("b2b_rdata2", m0_rdata, 32'h1111_2222);
        tick();

        // Reset in the second BUSY cycle, stale mem_ack afterwards
        m1_req = 1'b1; m1_addr = 32'h400;
        tick();
        tick();
        check("rstmid_busy", 32'(mem_req), 32'd1);
        rst = 1'b1; m1_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("rstmid_owner", 32'(grant_owner), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_ack = 1'b0;
        check("stale_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("stale_req", 32'(mem_req), 32'd0);
        check("stale_m1_rdata", m1_rdata, 32'd0);
        tick();
        check("stale_acks2", {30'd0, m1_ack, m0_ack}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog expiry after 8 BUSY cycles
        m0_req = 1'b1; m0_addr = 32'h500;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("tmo_still_busy", 32'(mem_req), 32'd1);
        tick();
        m0_req = 1'b0;
        check("tmo_req_drop", 32'(mem_req), 32'd0);
        check("tmo_ack", 32'(m0_ack), 32'd1);
        check("tmo_rdata", m0_rdata, 32'hFFFF_FFFF);
        check("tmo_err", 32'(err), 32'd1);
        tick();
        check("tmo_err_clear", 32'(err), 32'd0);
        // mem_ack in the expiry cycle wins
        m0_req = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ack = 1'b0; m0_req = 1'b0;
        check("tmo_race_ack", 32'(m0_ack), 32'd1);
        check("tmo_race_err", 32'(err), 32'd0);
        check("tmo_race_rdata", m0_rdata, 32'h1357_9BDF);
        tick();
`else
        // Without the watchdog BUSY waits indefinitely
        m0_req = 1'b1; m0_addr = 32'h500;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("nowd_busy", 32'(mem_req), 32'd1);
        check("nowd_err", 32'(err), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h2468_ACE0;
        tick();
        mem_ack = 1'b0; m0_req = 1'b0;
        check("nowd_ack", 32'(m0_ack), 32'd1);
        check("nowd_rdata", m0_rdata, 32'h2468_ACE0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
